// File: rtl/att_sched_pkg.sv
// Shared defaults, state encoding and index-width helper for the attenuator update scheduler.
package att_sched_pkg;

  localparam int N_CH_DEF    = 16;
  localparam int N_BITS_DEF  = 6;
  localparam int CLK_DIV_DEF = 200;
  localparam int LE_HOLD_DEF = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_LATCH,
    ST_GAP
  } sched_state_t;

  // Index width with a floor of one bit so single-entry counters still elaborate.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/att_spi_shift.sv
// SPI bit engine: shifts N_BITS MSB first, CLK_DIV/2 cycles SCK low then CLK_DIV/2 high per bit.
// First bit appears the cycle after start; last_edge flags the cycle before the final SCK fall.
module att_spi_shift
  import att_sched_pkg::*;
#(
  parameter int N_BITS  = N_BITS_DEF,
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [N_BITS-1:0] data,
  output logic              spi_clk,
  output logic              spi_mosi,
  output logic              last_edge
);

  localparam int HALF  = CLK_DIV / 2;
  localparam int HC_W  = idx_w(HALF);
  localparam int BIT_W = idx_w(N_BITS);

  logic              active;
  logic [HC_W-1:0]   hcnt;
  logic [BIT_W-1:0]  bcnt;
  logic [N_BITS-1:0] sreg;

  assign last_edge = active && spi_clk && (hcnt == HC_W'(HALF - 1)) &&
                     (bcnt == BIT_W'(N_BITS - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active   <= 1'b0;
      hcnt     <= '0;
      bcnt     <= '0;
      sreg     <= '0;
      spi_clk  <= 1'b0;
      spi_mosi <= 1'b0;
    end else if (start) begin
      active   <= 1'b1;
      hcnt     <= '0;
      bcnt     <= '0;
      sreg     <= data;
      spi_clk  <= 1'b0;
      spi_mosi <= data[N_BITS-1];
    end else if (active) begin
      if (hcnt == HC_W'(HALF - 1)) begin
        hcnt <= '0;
        if (!spi_clk) begin
          spi_clk <= 1'b1;
        end else begin
          // End of a high phase: either finish or present the next bit with SCK falling.
          spi_clk <= 1'b0;
          if (last_edge) begin
            active   <= 1'b0;
            spi_mosi <= 1'b0;
          end else begin
            bcnt     <= bcnt + 1'b1;
            sreg     <= {sreg[N_BITS-2:0], 1'b0};
            spi_mosi <= sreg[N_BITS-2];
          end
        end
      end else begin
        hcnt <= hcnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/att_update_sched.sv
// Round-robin scheduler pushing shadow attenuation codes over one shared SPI pair, then pulsing LE.
// done fires 3 + N_BITS*CLK_DIV + LE_HOLD cycles after a write in IDLE; writes are never stalled.
// ATT_POWERUP_LOAD_EN: reset loads max attenuation into every shadow and marks all channels pending.
module att_update_sched
  import att_sched_pkg::*;
#(
  parameter  int N_CH    = N_CH_DEF,
  parameter  int N_BITS  = N_BITS_DEF,
  parameter  int CLK_DIV = CLK_DIV_DEF,
  parameter  int LE_HOLD = LE_HOLD_DEF,
  localparam int CH_W    = idx_w(N_CH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [N_BITS-1:0] wr_data,
  input  logic [N_CH-1:0]   ch_mask,
  output logic [N_CH-1:0]   pending,
  output logic              busy,
  output logic              spi_clk,
  output logic              spi_mosi,
  output logic [N_CH-1:0]   le,
  output logic              done,
  output logic [CH_W-1:0]   done_ch
);

  localparam int LAT_W = idx_w(LE_HOLD);

`ifdef ATT_POWERUP_LOAD_EN
  localparam logic [N_BITS-1:0] SHADOW_RST = '1;
  localparam logic [N_CH-1:0]   PEND_RST   = '1;
`else
  localparam logic [N_BITS-1:0] SHADOW_RST = '0;
  localparam logic [N_CH-1:0]   PEND_RST   = '0;
`endif

  sched_state_t      state, state_nxt;
  logic [N_BITS-1:0] shadow [N_CH];
  logic [N_CH-1:0]   pend_q, pend_nxt, eligible;
  logic [CH_W-1:0]   rr_ptr, cur_ch, pick_ch;
  logic [LAT_W-1:0]  lat_cnt;
  logic              pick_vld, shift_start, last_edge, wr_ok;

  assign wr_ok    = wr_en && (int'(wr_ch) < N_CH);
  assign eligible = pend_q & ch_mask;
  assign pending  = pend_q;

  // Scan downward so the lowest offset from rr_ptr is the last (winning) assignment.
  always_comb begin : rr_pick
    logic [CH_W-1:0] idx;
    pick_vld = 1'b0;
    pick_ch  = '0;
    idx      = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      idx = CH_W'((int'(rr_ptr) + i) % N_CH);
      if (eligible[idx]) begin
        pick_vld = 1'b1;
        pick_ch  = idx;
      end
    end
  end

  // A write landing on cur_ch during LOAD re-arms pending so the newer code is sent later.
  always_comb begin
    pend_nxt = pend_q;
    if (state == ST_LOAD) pend_nxt[cur_ch] = 1'b0;
    if (wr_ok)            pend_nxt[wr_ch]  = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_q <= PEND_RST;
      for (int i = 0; i < N_CH; i++) shadow[i] <= SHADOW_RST;
    end else begin
      pend_q <= pend_nxt;
      if (wr_ok) shadow[wr_ch] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    busy        = (state != ST_IDLE);
    shift_start = 1'b0;
    le          = '0;
    done        = 1'b0;
    done_ch     = '0;
    case (state)
      ST_IDLE:  if (pick_vld) state_nxt = ST_LOAD;
      ST_LOAD: begin
        shift_start = 1'b1;
        state_nxt   = ST_SHIFT;
      end
      ST_SHIFT: if (last_edge) state_nxt = ST_LATCH;
      ST_LATCH: begin
        le[cur_ch] = 1'b1;
        if (lat_cnt == LAT_W'(LE_HOLD - 1)) state_nxt = ST_GAP;
      end
      ST_GAP: begin
        done      = 1'b1;
        done_ch   = cur_ch;
        state_nxt = ST_IDLE;
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_ch  <= '0;
      rr_ptr  <= '0;
      lat_cnt <= '0;
    end else begin
      if (state == ST_IDLE && pick_vld) cur_ch <= pick_ch;
      if (state == ST_GAP) rr_ptr <= (int'(cur_ch) == N_CH - 1) ? '0 : cur_ch + 1'b1;
      lat_cnt <= (state == ST_LATCH) ? lat_cnt + 1'b1 : '0;
    end
  end

  att_spi_shift #(
    .N_BITS  (N_BITS),
    .CLK_DIV (CLK_DIV)
  ) u_shift (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (shift_start),
    .data      (shadow[cur_ch]),
    .spi_clk   (spi_clk),
    .spi_mosi  (spi_mosi),
    .last_edge (last_edge)
  );

endmodule

// File: tb/tb_att_update_sched.sv
// Bench for att_update_sched: transaction-timeline reference model plus SPI/LE pin decoding.
module tb_att_update_sched;

  localparam int N     = 16;
  localparam int NB    = 6;
  localparam int CD    = 4;
  localparam int LEH   = 4;
  localparam int TOT_K = NB * CD + LEH + 1;

`ifdef ATT_POWERUP_LOAD_EN
  localparam logic [15:0] PEND_RST = 16'hFFFF;
  localparam logic [5:0]  SH_RST   = 6'h3F;
`else
  localparam logic [15:0] PEND_RST = 16'h0000;
  localparam logic [5:0]  SH_RST   = 6'h00;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_ch = '0;
  logic [5:0]  wr_data = '0;
  logic [15:0] ch_mask = '1;
  logic [15:0] pending, le;
  logic        busy, spi_clk, spi_mosi, done;
  logic [3:0]  done_ch;

  att_update_sched #(.N_CH(N), .N_BITS(NB), .CLK_DIV(CD), .LE_HOLD(LEH)) dut (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data),
    .ch_mask(ch_mask), .pending(pending), .busy(busy), .spi_clk(spi_clk),
    .spi_mosi(spi_mosi), .le(le), .done(done), .done_ch(done_ch)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Model: m_k = -1 idle, else cycle offset inside a transaction (0 = LOAD).
  logic [5:0]  m_shadow [N];
  logic [15:0] m_pend;
  logic [5:0]  m_code;
  int          m_rr, m_k, m_cur;

  logic        we_q = 1'b0;
  logic [3:0]  ch_q = '0;
  logic [5:0]  dat_q = '0;
  logic [15:0] mask_q = '1;

  logic        prev_sck;
  logic [5:0]  rx;
  int          rises, le_cyc, total_rises;
  typedef struct packed { logic [3:0] ch; logic [5:0] code; } xfer_t;
  xfer_t       done_q[$];

  function automatic xfer_t q_at(input int i);
    return (i < done_q.size()) ? done_q[i] : '1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_shadow[i] = SH_RST;
    m_pend = PEND_RST;
    m_code = '0;
    m_rr = 0; m_k = -1; m_cur = 0;
    prev_sck = 1'b0; rx = '0; rises = 0; le_cyc = 0;
  endtask

  task automatic model_step();
    logic [15:0] np, elig;
    int pick;
    np = m_pend;
    if (m_k < 0) begin
      elig = m_pend & ch_mask;
      pick = -1;
      for (int i = 0; i < N; i++)
        if (pick < 0 && elig[(m_rr + i) % N]) pick = (m_rr + i) % N;
      if (pick >= 0) begin m_cur = pick; m_k = 0; end
    end else if (m_k == 0) begin
      m_code = m_shadow[m_cur];
      np[m_cur] = 1'b0;
      m_k = 1;
    end else if (m_k == TOT_K) begin
      m_rr = (m_cur + 1) % N;
      m_k = -1;
    end else begin
      m_k++;
    end
    if (wr_en) begin m_shadow[wr_ch] = wr_data; np[wr_ch] = 1'b1; end
    m_pend = np;
  endtask

  task automatic check_outputs();
    logic        exp_sck, exp_done;
    logic [3:0]  exp_dch;
    logic [15:0] exp_le;
    int j;
    exp_sck = 1'b0; exp_done = 1'b0; exp_dch = '0; exp_le = '0;
    if (m_k >= 1 && m_k <= NB * CD) begin
      j = m_k - 1;
      exp_sck = ((j % CD) >= CD / 2);
      check_eq("mosi_bit", spi_mosi, m_code[NB - 1 - j / CD]);
    end else if (m_k > NB * CD && m_k <= NB * CD + LEH) begin
      exp_le = 16'(1) << m_cur;
    end else if (m_k == TOT_K) begin
      exp_done = 1'b1;
      exp_dch  = 4'(m_cur);
      check_eq("gap_mosi", spi_mosi, 0);
    end
    check_eq("busy_sck_done_le_pend", {busy, spi_clk, done, done_ch, le, pending},
             {m_k >= 0, exp_sck, exp_done, exp_dch, exp_le, m_pend});
    // Pin-level decode of the finished transaction.
    if (spi_clk && !prev_sck) begin rx = {rx[4:0], spi_mosi}; rises++; total_rises++; end
    prev_sck = spi_clk;
    if (le != '0) le_cyc++;
    if (done) begin
      check_eq("sck_pulses", rises, NB);
      check_eq("le_width", le_cyc, LEH);
      check_eq("rx_code", rx, m_code);
      done_q.push_back({done_ch, rx});
      rises = 0; le_cyc = 0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_outputs();
    wr_en = we_q; wr_ch = ch_q; wr_data = dat_q; ch_mask = mask_q;
    we_q = 1'b0;
    @(posedge clk);
    model_step();
  endtask

  task automatic write(input logic [3:0] ch, input logic [5:0] d);
    we_q = 1'b1; ch_q = ch; dat_q = d;
    tick();
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    do begin tick(); n++; end
    while (!(m_k < 0 && (m_pend & mask_q) == '0) && n < 3000);
    check_eq(tag, n >= 3000, 0);
  endtask

  task automatic run_to(input int k);
    for (int i = 0; i < 100 && m_k != k; i++) tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sck_before;
    model_reset();
    total_rises = 0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_pins", {busy, spi_clk, spi_mosi, done, done_ch, le}, 0);
    check_eq("rst_pending", pending, PEND_RST);
    #1 reset_n = 1'b1;

`ifdef ATT_POWERUP_LOAD_EN
    wait_idle("pwrup_idle");
    check_eq("pwrup_count", done_q.size(), 16);
    for (int i = 0; i < 16; i++) check_eq("pwrup_xfer", q_at(i), {4'(i), 6'h3F});
    check_eq("pwrup_pending", pending, 0);
`endif

    // Two channels from rr_ptr 0, then a pair behind rr_ptr 13 that must wrap.
    done_q.delete();
    write(4'd3, 6'h11); write(4'd12, 6'h22);
    wait_idle("rr_a_idle");
    check_eq("rr_a_count", done_q.size(), 2);
    check_eq("rr_a_first", q_at(0), {4'd3, 6'h11});
    check_eq("rr_a_second", q_at(1), {4'd12, 6'h22});
    done_q.delete();
    write(4'd3, 6'h05); write(4'd4, 6'h06);
    wait_idle("rr_b_idle");
    check_eq("rr_b_first", q_at(0), {4'd3, 6'h05});
    check_eq("rr_b_second", q_at(1), {4'd4, 6'h06});

    done_q.delete();
    write(4'd5, 6'h2A);
    wait_idle("ch5_idle");
    check_eq("ch5_count", done_q.size(), 1);
    check_eq("ch5_xfer", q_at(0), {4'd5, 6'h2A});
    check_eq("ch5_pending", pending, 0);

    // Masked channel holds its pending bit until unmasked.
    done_q.delete();
    mask_q = 16'hFF7F;
    sck_before = total_rises;
    write(4'd7, 6'h15);
    repeat (40) tick();
    check_eq("mask_no_sck", total_rises - sck_before, 0);
    check_eq("mask_pending7", pending[7], 1);
    check_eq("mask_no_done", done_q.size(), 0);
    mask_q = '1;
    wait_idle("mask_idle");
    check_eq("mask_xfer", q_at(0), {4'd7, 6'h15});

    // Rewrite during SHIFT: in-flight code is untouched, new code follows.
    done_q.delete();
    write(4'd2, 6'h01);
    run_to(8);
    write(4'd2, 6'h3E);
    wait_idle("rewrite_idle");
    check_eq("rewrite_count", done_q.size(), 2);
    check_eq("rewrite_first", q_at(0), {4'd2, 6'h01});
    check_eq("rewrite_second", q_at(1), {4'd2, 6'h3E});

    // Mask cleared mid-transaction: the transfer still completes.
    done_q.delete();
    write(4'd6, 6'h33);
    run_to(5);
    mask_q = '0;
    wait_idle("unmask_mid_idle");
    check_eq("unmask_mid_xfer", q_at(0), {4'd6, 6'h33});
    mask_q = '1;

    // Reset mid-SHIFT while SCK is high.
    write(4'd9, 6'h2D);
    run_to(11);
    #2 reset_n = 1'b0;
    #1;
    check_eq("rst_mid_pins", {spi_clk, spi_mosi, le, busy, done}, 0);
    check_eq("rst_mid_pending", pending, PEND_RST);
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    model_reset();
    done_q.delete();
`ifdef ATT_POWERUP_LOAD_EN
    wait_idle("rst_mid_reload");
    check_eq("rst_mid_reload_count", done_q.size(), 16);
`else
    repeat (40) tick();
    check_eq("rst_mid_quiet", done_q.size(), 0);
`endif

    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 5) == 0) begin
        we_q = 1'b1; ch_q = 4'($urandom_range(0, 15)); dat_q = 6'($urandom);
      end
      if ($urandom_range(0, 39) == 0) mask_q = 16'($urandom) | 16'($urandom);
      tick();
    end
    mask_q = '1;
    wait_idle("rand_drain");
    check_eq("rand_pending", pending, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/att_update_sched.md
Name: att_update_sched

Overview:
- Scheduler for the 16-channel step-attenuator SPI bus.
- Holds a 6-bit shadow code per channel, written from the register side, and tracks a per-channel dirty flag.
- Serialises pending updates round-robin onto a single shared SCK/SDI pair, then pulses the selected channel's LE.
- Sits between the AXI register file and the attenuator pins, in the clk_200 domain.

Parameters:
- N_CH, 16, number of attenuator channels (LE lines); channel index width CH_W = clog2(N_CH).
- N_BITS, 6, code width shifted per transaction, MSB first.
- CLK_DIV, 200, clk cycles per SCK period; must be even and >= 2.
- LE_HOLD, 4, clk cycles LE is held high after the last SCK falling edge.

Ports:
- clk  in  1  clk_200 domain clock.
- reset_n  in  1  asynchronous active-low reset.
- wr_en  in  1  single-cycle shadow write strobe.
- wr_ch  in  CH_W  channel index for the write.
- wr_data  in  N_BITS  attenuation code for the write.
- ch_mask  in  N_CH  1 = channel eligible for scheduling.
- pending  out  N_CH  dirty flags.
- busy  out  1  high in every state except IDLE.
- spi_clk  out  1  SCK; idles low.
- spi_mosi  out  1  SDI.
- le  out  N_CH  one-hot latch enable, active high.
- done  out  1  one-cycle pulse at the end of a transaction.
- done_ch  out  CH_W  channel completed; valid only when done is high.

Behaviour:
- Reset (asynchronous, reset_n low):
  - State = IDLE; shadows = 0; pending = 0; rr_ptr = 0.
  - All outputs are 0, including spi_clk, spi_mosi, le, busy, done and done_ch.
  - Asserting reset mid-transaction aborts the transaction immediately; no LE pulse is produced.
- Writes:
  - wr_en at cycle t updates shadow[wr_ch] and sets pending[wr_ch], both visible at t+1.
  - A write to an index >= N_CH is ignored.
  - Writes are accepted in every state.
- States: IDLE -> LOAD -> SHIFT -> LATCH -> GAP -> IDLE.
- IDLE:
  - If (pending & ch_mask) != 0, select the first set bit scanning from rr_ptr upward with wrap-around.
  - Register the selected channel as cur_ch and go to LOAD.
- LOAD (1 cycle):
  - Copy shadow[cur_ch] into the shift register and clear pending[cur_ch].
  - A wr_en to cur_ch in this same cycle wins: pending stays set and the new value is resent later.
- SHIFT (N_BITS * CLK_DIV cycles):
  - Each bit = CLK_DIV/2 cycles with spi_clk low, then CLK_DIV/2 cycles with spi_clk high.
  - spi_mosi presents the bit at the start of its low phase and holds it for the whole bit.
  - spi_clk returns low after the last high phase.
- LATCH (LE_HOLD cycles): le[cur_ch] = 1; all other le bits stay 0.
- GAP (1 cycle):
  - le = 0, spi_mosi = 0.
  - done = 1, done_ch = cur_ch.
  - rr_ptr = (cur_ch + 1) mod N_CH.
- Latency:
  - wr_en at cycle 0 in IDLE gives LOAD at cycle 2 and the first spi_clk rise at cycle 3 + CLK_DIV/2.
  - done occurs at cycle 3 + N_BITS*CLK_DIV + LE_HOLD.
- Shift data is the LOAD-time copy; later shadow writes do not disturb an in-flight transaction.
- Masked channels keep their pending bit and are scheduled once unmasked.
- If ch_mask is cleared mid-transaction, the current transaction still completes.
- Back-to-back: the next channel may be selected in the IDLE cycle after GAP, giving a minimum 2-cycle gap between LE falling and the next SCK activity.
- Fairness: the round-robin pointer guarantees each eligible channel is served within N_CH transactions.

Optional Feature:
- ATT_POWERUP_LOAD_EN defined:
  - Reset sets every shadow to all-ones (max attenuation) and pending to all-ones.
  - After reset the scheduler pushes max attenuation to all unmasked channels, 0 to N_CH-1 in order.
- Undefined: shadows and pending reset to 0, and nothing is sent until the first write.

Decomposition:
- Shared package att_sched_pkg:
  - State encoding (IDLE, LOAD, SHIFT, LATCH, GAP).
  - Default N_CH, N_BITS, CLK_DIV, LE_HOLD.
  - CH_W derivation.
- Sub-module att_spi_shift: bit engine with start / N_BITS data in, and spi_clk, spi_mosi and last_edge out. It contains the CLK_DIV half-period counter and the bit counter.
- The scheduler keeps the shadows, pending flags, round-robin pick and LE timing.

Test Plan:
- Write ch5 = 6'h2A, ch_mask = all ones, CLK_DIV = 4, LE_HOLD = 4 -> 6 SCK pulses, SDI 1,0,1,0,1,0; le[5] high exactly 4 cycles; done_ch = 5; pending = 0.
- Write ch3 and ch12 in the same idle window with rr_ptr = 0 -> ch3 served first, then ch12; next write to ch3 and ch4 after that -> ch3 then ch4, with rr_ptr = 13 wrapping.
- Write ch7 with ch_mask[7] = 0 -> no SCK, pending[7] = 1; set mask bit -> transaction runs with the stored code.
- Write ch2 = 6'h01, then ch2 = 6'h3E during its SHIFT -> first transfer sends 6'h01, and a second transfer sends 6'h3E.
- Deassert reset_n mid-SHIFT -> spi_clk, spi_mosi, le, busy and pending are 0 immediately; after release, no transaction starts (macro undefined).
- With ATT_POWERUP_LOAD_EN -> after reset, 16 transactions of 6'h3F on ch0..ch15 in order; pending is all-zero at the end.
